dm_access_ctrl: RTL
===================

# dm_access_ctrl

MEM-stage data-memory access controller for the 5-stage RV32 pipeline. It turns one load or store request from the EX/MEM register into the DM AR/R or AW/W handshakes on the 128-bit line interface, and holds the pipeline stalled until the transfer finishes. It also handles byte-lane placement, write strobes, load sign/zero extension and misalignment detection. It replaces the fixed-VALID/always-ready DM wiring in top.

## Interface
No parameters. Data line is fixed at 128 bits, 16 byte lanes.

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  MEM stage holds a load/store; stable while stall=1
- req_we  in  1  1=store, 0=load
- req_addr  in  32  byte address
- req_size  in  2  0=byte, 1=half, 2=word; 3 is illegal and treated as misaligned
- req_unsigned  in  1  load zero-extends (LBU/LHU)
- req_wdata  in  32  store data, right-justified
- stall  out  1  freeze PC and IF/ID/ID-EX/EX-MEM registers
- done  out  1  one-cycle completion pulse
- err  out  1  misaligned access; valid with done
- rdata  out  32  extended load data; valid with done, held until next done
- ARADDR_DM  out  32,  ARVALID_DM  out  1,  ARREADY_DM  in  1
- RDATA_DM  in  128,  RVALID_DM  in  1,  RREADY_DM  out  1
- AWADDR_DM  out  32,  AWVALID_DM  out  1,  AWREADY_DM  in  1
- WDATA_DM  out  128,  WSTRB_DM  out  16,  WVALID_DM  out  1,  WREADY_DM  in  1

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR, DONE.
- Acceptance: in IDLE with req_valid=1, the controller registers the request. Line address is {req_addr[31:4],4'h0}; offset is req_addr[3:0].
- Misaligned: half with addr[0]=1, word with addr[1:0]≠0, or size=3.
  - Goes to DONE with err=1.
  - No bus transaction is issued.
- IDLE → RD_ADDR on a load, → WR on a store.
- RD_ADDR: ARVALID_DM=1 with ARADDR_DM equal to the line address. On ARREADY_DM → RD_DATA.
- RD_DATA: RREADY_DM=1.
  - On RVALID_DM, take byte lane RDATA_DM[offset*8 +: 8/16/32] by size.
  - Sign-extend unless req_unsigned is set. Register the result into rdata, then → DONE.
- WR: AWVALID_DM and WVALID_DM both assert on entry. Each deasserts independently after its own handshake (tracked by aw_done and w_done). → DONE when both are complete; same-cycle completion is allowed.
- Write data and strobes:
  - WDATA_DM = req_wdata zero-extended to 128 bits, shifted left by offset*8.
  - WSTRB_DM = (size 0: 16'h0001, 1: 16'h0003, 2: 16'h000F) << offset.
  - Both are 0 outside WR.
- DONE: done=1, stall=0, → IDLE unconditionally. The request visible during DONE is the completed one and is not re-accepted.
- stall = !rst & ((IDLE & req_valid) | RD_ADDR | RD_DATA | WR).
- VALID rule: while any VALID is high, its address, data and strobe stay stable until the handshake. VALID never drops before READY.
- Reset: asynchronous, effective immediately, including mid-transfer.
  - State → IDLE.
  - All VALID/READY outputs, done, err, rdata, ARADDR_DM, AWADDR_DM, WDATA_DM and WSTRB_DM → 0.
  - An aborted transfer is not resumed.

## Timing
- Load with ARREADY and RVALID both high at first opportunity:
  - T0 IDLE accepts.
  - T1 AR handshake.
  - T2 R handshake.
  - T3 DONE.
  - stall is high T0–T2 and low at T3. Minimum 4 cycles.
- Store with AWREADY and WREADY high: T0 accept, T1 AW+W handshake, T2 DONE. Minimum 3 cycles.
- Misaligned: T0 accept, T1 DONE with err=1.
- Each cycle of READY/RVALID delay adds one cycle in the waiting state.
- Back-to-back requests: earliest next acceptance is the cycle after DONE.
- rdata and err update on the cycle done rises.

## Test plan
- LW at 0x0000_1008, RDATA_DM[95:64]=0xDEAD_BEEF, zero wait states:
  - ARADDR_DM=0x0000_1000.
  - done at T3 with rdata=0xDEADBEEF.
  - stall high for exactly 3 cycles.
- LB / LBU at 0x...0005 with byte 0x80:
  - LB gives rdata=0xFFFF_FF80; LBU gives 0x0000_0080.
- SH 0xABCD to 0x...000E, AWREADY delayed 3 cycles, WREADY immediate:
  - WSTRB_DM=16'hC000, WDATA_DM[127:112]=0xABCD.
  - WVALID drops after 1 cycle; AWVALID holds until its handshake.
  - done 1 cycle after the AW handshake.
- LW at 0x...0002:
  - done at T1 with err=1.
  - ARVALID_DM never asserts.
- Async rst pulse while in RD_DATA waiting on RVALID:
  - All outputs go to 0 immediately and state returns to IDLE.
  - A later RVALID is ignored.
  - The next request completes normally.
- Two back-to-back SW requests:
  - The second is accepted the cycle after the first's DONE.
  - No duplicate AW/W handshake occurs.

Source files
------------

// File: rtl/dm_access_ctrl.sv
// MEM-stage data-memory access controller: turns one load/store into AR/R or AW/W
// handshakes on the 128-bit DM line interface and stalls the pipeline until the transfer completes.
module dm_access_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  input  logic         req_we,
  input  logic [31:0]  req_addr,
  input  logic [1:0]   req_size,
  input  logic         req_unsigned,
  input  logic [31:0]  req_wdata,
  output logic         stall,
  output logic         done,
  output logic         err,
  output logic [31:0]  rdata,
  output logic [31:0]  ARADDR_DM,
  output logic         ARVALID_DM,
  input  logic         ARREADY_DM,
  input  logic [127:0] RDATA_DM,
  input  logic         RVALID_DM,
  output logic         RREADY_DM,
  output logic [31:0]  AWADDR_DM,
  output logic         AWVALID_DM,
  input  logic         AWREADY_DM,
  output logic [127:0] WDATA_DM,
  output logic [15:0]  WSTRB_DM,
  output logic         WVALID_DM,
  input  logic         WREADY_DM
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [31:0] wdata_q, wdata_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic          misaligned;
  logic [31:0]   line_addr;
  logic [6:0]    bit_shift;
  logic [31:0]   rd_word;
  logic [31:0]   load_ext;
  logic [127:0]  wdata_line;
  logic [15:0]   strb_base;
  logic [3:0]    lane_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      unsigned_q <= 1'b0;
      wdata_q    <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      wdata_q    <= wdata_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  // Lane gather wraps within the line; wrapped bytes are only ever discarded by the size mux.
  always_comb begin
    misaligned = (req_size == 2'd3) ||
                 ((req_size == 2'd1) && req_addr[0]) ||
                 ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
    line_addr  = {addr_q[31:4], 4'h0};
    bit_shift  = {addr_q[3:0], 3'b000};
    rd_word    = '0;
    lane_idx   = '0;
    for (int i = 0; i < 4; i++) begin
      lane_idx          = addr_q[3:0] + 4'(i);
      rd_word[i*8 +: 8] = RDATA_DM[{lane_idx, 3'b000} +: 8];
    end
    case (size_q)
      2'd0:    load_ext = unsigned_q ? {24'h0, rd_word[7:0]}  : {{24{rd_word[7]}}, rd_word[7:0]};
      2'd1:    load_ext = unsigned_q ? {16'h0, rd_word[15:0]} : {{16{rd_word[15]}}, rd_word[15:0]};
      default: load_ext = rd_word;
    endcase
    case (size_q)
      2'd0:    strb_base = 16'h0001;
      2'd1:    strb_base = 16'h0003;
      default: strb_base = 16'h000F;
    endcase
    wdata_line = {96'h0, wdata_q} << bit_shift;
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    wdata_d    = wdata_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d     = req_addr;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          wdata_d    = req_wdata;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          err_d      = misaligned;
          if (misaligned)  state_d = DONE;
          else if (req_we) state_d = WR;
          else             state_d = RD_ADDR;
        end
      end
      RD_ADDR: if (ARREADY_DM) state_d = RD_DATA;
      RD_DATA: begin
        if (RVALID_DM) begin
          rdata_d = load_ext;
          state_d = DONE;
        end
      end
      // AW and W retire independently; a channel's READY only matters while its VALID is still up.
      WR: begin
        aw_done_d = aw_done_q | AWREADY_DM;
        w_done_d  = w_done_q  | WREADY_DM;
        if (aw_done_d && w_done_d) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ARVALID_DM = (state_q == RD_ADDR);
    ARADDR_DM  = ARVALID_DM ? line_addr : 32'h0;
    RREADY_DM  = (state_q == RD_DATA);
    AWVALID_DM = (state_q == WR) && !aw_done_q;
    WVALID_DM  = (state_q == WR) && !w_done_q;
    AWADDR_DM  = (state_q == WR) ? line_addr : 32'h0;
    WDATA_DM   = (state_q == WR) ? wdata_line : 128'h0;
    WSTRB_DM   = (state_q == WR) ? (strb_base << addr_q[3:0]) : 16'h0;
    done       = (state_q == DONE);
    err        = done && err_q;
    rdata      = rdata_q;
    stall      = !rst && (((state_q == IDLE) && req_valid) || (state_q == RD_ADDR) ||
                          (state_q == RD_DATA) || (state_q == WR));
  end

endmodule
